// File: rtl/video_squ_pkg.sv
// Shared constants, types and helpers for the square-pixel NTSC raster timing generator.
// Macro VIDEO_SQU_TG_SERRATION_EN selects equalizing / serrated vertical sync lines.
package video_squ_pkg;

  localparam logic [9:0] H_LAST      = 10'd779;   // H_TOTAL = 780
  localparam logic [8:0] V_LAST      = 9'd262;    // V_TOTAL = 263

  localparam logic [9:0] H_SYNC_END  = 10'd57;
  localparam logic [9:0] H_BURST_BEG = 10'd65;
  localparam logic [9:0] H_BURST_END = 10'd95;
  localparam logic [9:0] H_ACT_BEG   = 10'd130;
  localparam logic [9:0] H_ACT_END   = 10'd769;
  localparam logic [9:0] H_EQ_END    = 10'd28;
  localparam logic [9:0] H_HALF      = 10'd390;
  localparam logic [9:0] H_EQ2_END   = 10'd418;
  localparam logic [9:0] H_VS1_END   = 10'd331;
  localparam logic [9:0] H_VS2_END   = 10'd721;

  localparam logic [8:0] V_EQ1_END   = 9'd2;
  localparam logic [8:0] V_VS_BEG    = 9'd3;
  localparam logic [8:0] V_VS_END    = 9'd5;
  localparam logic [8:0] V_EQ2_END   = 9'd8;
  localparam logic [8:0] V_BURST_BEG = 9'd9;
  localparam logic [8:0] V_ACT_BEG   = 9'd20;
  localparam logic [8:0] V_ACT_END   = 9'd259;

  localparam logic [4:0] PH_STEP     = 5'd7;
  localparam logic [4:0] PH_MOD      = 5'd24;
  localparam logic [4:0] PH_QUARTER  = 5'd6;

  // First quarter of the sine wave in 15 degree steps, amplitude 7; entry k at [k].
  localparam logic [6:0][2:0] SIN_Q = {3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd0};

  typedef enum logic [1:0] {LINE_NORMAL, LINE_EQ, LINE_VSYNC} line_kind_e;

  typedef struct packed {
    logic xsync;
    logic xblk;
    logic burst;
  } gates_t;

  localparam gates_t GATES_RST = '{xsync: 1'b1, xblk: 1'b0, burst: 1'b0};

  function automatic logic signed [3:0] sin_lut(input logic [4:0] p);
    logic       neg;
    logic [4:0] q;
    logic [2:0] mag;
    neg = (p >= 5'd12);
    q   = neg ? p - 5'd12 : p;
    mag = (q <= 5'd6) ? SIN_Q[q[2:0]] : SIN_Q[3'(5'd12 - q)];
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic line_kind_e line_kind(input logic [8:0] v);
`ifdef VIDEO_SQU_TG_SERRATION_EN
    if (v <= V_EQ1_END || (v > V_VS_END && v <= V_EQ2_END)) return LINE_EQ;
`endif
    if (v >= V_VS_BEG && v <= V_VS_END) return LINE_VSYNC;
    return LINE_NORMAL;
  endfunction

endpackage

// File: rtl/video_squ_timing_gen_subcarrier.sv
// Colour subcarrier: 24-step phase accumulator advancing 7 steps per clock, sin/cos LUT
// and a C_DLY-stage output delay line.
module video_squ_subcarrier
  import video_squ_pkg::*;
#(
  parameter int C_DLY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              srst,
  output logic signed [3:0] sin_o,
  output logic signed [3:0] cos_o
);

  logic [4:0] ph_q, ph_d, ph_sum, cos_idx_sum, cos_idx;
  logic signed [3:0] sin_q [C_DLY];
  logic signed [3:0] sin_d [C_DLY];
  logic signed [3:0] cos_q [C_DLY];
  logic signed [3:0] cos_d [C_DLY];

  assign ph_sum      = ph_q + PH_STEP;
  assign cos_idx_sum = ph_q + PH_QUARTER;
  assign cos_idx     = (cos_idx_sum >= PH_MOD) ? cos_idx_sum - PH_MOD : cos_idx_sum;

  always_comb begin
    ph_d = ph_q;
    for (int i = 0; i < C_DLY; i++) begin
      sin_d[i] = sin_q[i];
      cos_d[i] = cos_q[i];
    end
    if (srst) begin
      ph_d = '0;
      for (int i = 0; i < C_DLY; i++) begin
        sin_d[i] = '0;
        cos_d[i] = '0;
      end
    end else if (ce) begin
      ph_d     = (ph_sum >= PH_MOD) ? ph_sum - PH_MOD : ph_sum;
      sin_d[0] = sin_lut(ph_q);
      cos_d[0] = sin_lut(cos_idx);
      for (int i = 1; i < C_DLY; i++) begin
        sin_d[i] = sin_q[i-1];
        cos_d[i] = cos_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
      for (int i = 0; i < C_DLY; i++) begin
        sin_q[i] <= '0;
        cos_q[i] <= '0;
      end
    end else begin
      ph_q <= ph_d;
      for (int i = 0; i < C_DLY; i++) begin
        sin_q[i] <= sin_d[i];
        cos_q[i] <= cos_d[i];
      end
    end
  end

  assign sin_o = sin_q[C_DLY-1];
  assign cos_o = cos_q[C_DLY-1];

endmodule

// File: rtl/video_squ_timing_gen.sv
// Square-pixel NTSC raster timing: H/V/frame counters, delayed sync/blank/burst gates, subcarrier.
// Define VIDEO_SQU_TG_SERRATION_EN for equalizing lines and serrated vertical sync.
module video_squ_timing_gen
  import video_squ_pkg::*;
#(
  parameter int C_PX_DLY       = 3,
  parameter int C_CBURST_DLY_N = 2,
  parameter bit C_XCBURST_SHUF = 1'b0
) (
  input  logic              CK_i,
  input  logic              XARST_i,
  input  logic              CK_EE_i,
  input  logic              RST_i,
  output logic [9:0]        HCTRs_o,
  output logic [8:0]        VCTRs_o,
  output logic [7:0]        FCTRs_o,
  output logic              XBLK_o,
  output logic              COLOR_BAR_NOW_o,
  output logic              XSYNC_o,
  output logic signed [3:0] sin_s_o,
  output logic signed [3:0] cos_s_o
);

  logic [9:0] hctr_q, hctr_d;
  logic [8:0] vctr_q, vctr_d;
  logic [7:0] fctr_q, fctr_d;
  logic       h_wrap, v_wrap;
  gates_t     gate_now;
  gates_t     gates_q [C_PX_DLY];
  gates_t     gates_d [C_PX_DLY];
  line_kind_e kind;
  logic       in_sync;

  assign h_wrap = (hctr_q == H_LAST);
  assign v_wrap = (vctr_q == V_LAST);

  // NOTE: every always_comb output gets a hold value first so no path infers a latch.
  always_comb begin
    hctr_d = hctr_q;
    vctr_d = vctr_q;
    fctr_d = fctr_q;
    if (RST_i) begin
      hctr_d = '0;
      vctr_d = '0;
      fctr_d = '0;
    end else if (CK_EE_i) begin
      hctr_d = h_wrap ? '0 : hctr_q + 10'd1;
      if (h_wrap) begin
        vctr_d = v_wrap ? '0 : vctr_q + 9'd1;
        if (v_wrap) fctr_d = fctr_q + 8'd1;
      end
    end
  end

  always_comb begin
    kind    = line_kind(vctr_q);
    in_sync = (hctr_q <= H_SYNC_END);
    case (kind)
      LINE_EQ:    in_sync = (hctr_q <= H_EQ_END) || (hctr_q >= H_HALF && hctr_q <= H_EQ2_END);
`ifdef VIDEO_SQU_TG_SERRATION_EN
      LINE_VSYNC: in_sync = (hctr_q <= H_VS1_END) || (hctr_q >= H_HALF && hctr_q <= H_VS2_END);
`else
      LINE_VSYNC: in_sync = (hctr_q <= H_VS2_END);
`endif
      default:    ;
    endcase
    gate_now.xsync = ~in_sync;
    gate_now.xblk  = (vctr_q >= V_ACT_BEG) && (vctr_q <= V_ACT_END) &&
                     (hctr_q >= H_ACT_BEG) && (hctr_q <= H_ACT_END);
    gate_now.burst = !C_XCBURST_SHUF && (vctr_q >= V_BURST_BEG) &&
                     (hctr_q >= H_BURST_BEG) && (hctr_q <= H_BURST_END);
  end

  always_comb begin
    for (int i = 0; i < C_PX_DLY; i++) gates_d[i] = gates_q[i];
    if (RST_i) begin
      for (int i = 0; i < C_PX_DLY; i++) gates_d[i] = GATES_RST;
    end else if (CK_EE_i) begin
      gates_d[0] = gate_now;
      for (int i = 1; i < C_PX_DLY; i++) gates_d[i] = gates_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      hctr_q <= '0;
      vctr_q <= '0;
      fctr_q <= '0;
      // NOTE: the delay stages are a handful of flops, not a RAM, so they are reset with the counters.
      for (int i = 0; i < C_PX_DLY; i++) gates_q[i] <= GATES_RST;
    end else begin
      hctr_q <= hctr_d;
      vctr_q <= vctr_d;
      fctr_q <= fctr_d;
      for (int i = 0; i < C_PX_DLY; i++) gates_q[i] <= gates_d[i];
    end
  end

  video_squ_subcarrier #(
    .C_DLY (C_CBURST_DLY_N)
  ) u_subcarrier (
    .clk   (CK_i),
    .rst_n (XARST_i),
    .ce    (CK_EE_i),
    .srst  (RST_i),
    .sin_o (sin_s_o),
    .cos_o (cos_s_o)
  );

  assign HCTRs_o         = hctr_q;
  assign VCTRs_o         = vctr_q;
  assign FCTRs_o         = fctr_q;
  assign XSYNC_o         = gates_q[C_PX_DLY-1].xsync;
  assign XBLK_o          = gates_q[C_PX_DLY-1].xblk;
  assign COLOR_BAR_NOW_o = gates_q[C_PX_DLY-1].burst;

endmodule

// File: tb/tb_video_squ_timing_gen.sv
// Scoreboard bench for video_squ_timing_gen: a behavioural raster model queues expected outputs
// each enabled clock; a second instance checks burst suppression.
module tb_video_squ_timing_gen;

  localparam int PX_DLY = 3;
  localparam int SC_DLY = 2;

  typedef struct packed {
    logic xsync;
    logic xblk;
    logic burst;
  } exp_gate_t;

  typedef struct {
    int s;
    int c;
  } exp_sc_t;

  logic clk, xarst, ck_ee, rst;
  logic [9:0] hctr, m_hctr;
  logic [8:0] vctr, m_vctr;
  logic [7:0] fctr, m_fctr;
  logic xblk, burst, xsync, m_xblk, m_burst, m_xsync;
  logic signed [3:0] sin_s, cos_s, m_sin, m_cos;

  video_squ_timing_gen #(.C_PX_DLY(PX_DLY), .C_CBURST_DLY_N(SC_DLY), .C_XCBURST_SHUF(1'b0)) dut (
    .CK_i(clk), .XARST_i(xarst), .CK_EE_i(ck_ee), .RST_i(rst),
    .HCTRs_o(hctr), .VCTRs_o(vctr), .FCTRs_o(fctr),
    .XBLK_o(xblk), .COLOR_BAR_NOW_o(burst), .XSYNC_o(xsync),
    .sin_s_o(sin_s), .cos_s_o(cos_s)
  );

  video_squ_timing_gen #(.C_PX_DLY(PX_DLY), .C_CBURST_DLY_N(SC_DLY), .C_XCBURST_SHUF(1'b1)) dut_mono (
    .CK_i(clk), .XARST_i(xarst), .CK_EE_i(ck_ee), .RST_i(rst),
    .HCTRs_o(m_hctr), .VCTRs_o(m_vctr), .FCTRs_o(m_fctr),
    .XBLK_o(m_xblk), .COLOR_BAR_NOW_o(m_burst), .XSYNC_o(m_xsync),
    .sin_s_o(m_sin), .cos_s_o(m_cos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state and scoreboard queues.
  int m_h, m_v, m_f, m_p;
  exp_gate_t q_g[$];
  exp_sc_t   q_s[$];
  exp_gate_t e_g;
  exp_sc_t   e_s;
  int sin_tab[24] = '{0, 2, 4, 5, 6, 7, 7, 7, 6, 5, 4, 2, 0, -2, -4, -5, -6, -7, -7, -7, -6, -5, -4, -2};

  // Measurements taken from the first pass through the frame.
  bit stats_en;
  int cyc;
  int first_low_cyc = -1;
  int l20_sync_cnt = 0, l20_sync_first = -1;
  int l20_burst_cnt = 0, l20_burst_first = -1;
  int l20_blk_cnt = 0, l20_blk_first = -1;
  int l4_low_cnt = 0;
  int early_burst_cnt = 0;
  int mono_burst_cnt = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_gate_t model_gates(input int h, input int v);
    exp_gate_t g;
    bit s, eq_line, vs_line;
    vs_line = (v >= 3 && v <= 5);
`ifdef VIDEO_SQU_TG_SERRATION_EN
    eq_line = (v <= 2) || (v >= 6 && v <= 8);
`else
    eq_line = 1'b0;
`endif
    if (vs_line) begin
`ifdef VIDEO_SQU_TG_SERRATION_EN
      s = (h <= 331) || (h >= 390 && h <= 721);
`else
      s = (h <= 721);
`endif
    end else if (eq_line) begin
      s = (h <= 28) || (h >= 390 && h <= 418);
    end else begin
      s = (h <= 57);
    end
    g.xsync = !s;
    g.xblk  = (v >= 20 && v <= 259 && h >= 130 && h <= 769);
    g.burst = (v >= 9 && h >= 65 && h <= 95);
    return g;
  endfunction

  task automatic model_flush();
    m_h = 0; m_v = 0; m_f = 0; m_p = 0;
    q_g.delete();
    q_s.delete();
    e_g = '{xsync: 1'b1, xblk: 1'b0, burst: 1'b0};
    e_s = '{s: 0, c: 0};
    for (int i = 0; i < PX_DLY - 1; i++) q_g.push_back(e_g);
    for (int i = 0; i < SC_DLY - 1; i++) q_s.push_back(e_s);
  endtask

  task automatic model_advance();
    exp_sc_t sc;
    q_g.push_back(model_gates(m_h, m_v));
    e_g = q_g.pop_front();
    sc.s = sin_tab[m_p];
    sc.c = sin_tab[(m_p + 6) % 24];
    q_s.push_back(sc);
    e_s = q_s.pop_front();
    m_p = (m_p + 7) % 24;
    if (m_h == 779) begin
      m_h = 0;
      if (m_v == 262) begin
        m_v = 0;
        m_f = (m_f + 1) % 256;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endtask

  task automatic compare_all();
    check("hctr", int'(hctr), m_h);
    check("vctr", int'(vctr), m_v);
    check("fctr", int'(fctr), m_f);
    check("xsync", int'(xsync), int'(e_g.xsync));
    check("xblk", int'(xblk), int'(e_g.xblk));
    check("burst", int'(burst), int'(e_g.burst));
    check("sin", int'(sin_s), e_s.s);
    check("cos", int'(cos_s), e_s.c);
    check("mono_burst", int'(m_burst), 0);
    if (m_burst) mono_burst_cnt++;
    if (stats_en) begin
      if (first_low_cyc < 0 && !xsync) first_low_cyc = cyc;
      if (vctr == 9'd20) begin
        if (!xsync) begin
          l20_sync_cnt++;
          if (l20_sync_first < 0) l20_sync_first = int'(hctr);
        end
        if (burst) begin
          l20_burst_cnt++;
          if (l20_burst_first < 0) l20_burst_first = int'(hctr);
        end
        if (xblk) begin
          l20_blk_cnt++;
          if (l20_blk_first < 0) l20_blk_first = int'(hctr);
        end
      end
      if (vctr == 9'd4 && !xsync) l4_low_cnt++;
      if (vctr <= 9'd8 && burst) early_burst_cnt++;
    end
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic cycle(input bit ee, input bit rs);
    ck_ee = ee;
    rst   = rs;
    @(posedge clk);
    if (rs) model_flush();
    else if (ee) model_advance();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    xarst = 1'b0;
    ck_ee = 1'b1;
    rst   = 1'b0;
    stats_en = 1'b1;
    cyc = 0;
    model_flush();
    repeat (3) @(negedge clk);
    compare_all();
    xarst = 1'b1;

    // Lines 0..21: reset release, vertical sync, blanking and the first active line.
    for (int n = 0; n < 16500; n++) cycle(1'b1, 1'b0);

    check("first_sync_cycle", first_low_cyc, PX_DLY);
    check("l20_sync_len", l20_sync_cnt, 58);
    check("l20_sync_start", l20_sync_first, 3);
    check("l20_burst_len", l20_burst_cnt, 31);
    check("l20_burst_start", l20_burst_first, 68);
    check("l20_blk_len", l20_blk_cnt, 640);
    check("l20_blk_start", l20_blk_first, 133);
`ifdef VIDEO_SQU_TG_SERRATION_EN
    check("l4_sync_low", l4_low_cnt, 664);
`else
    check("l4_sync_low", l4_low_cnt, 722);
`endif
    check("early_burst", early_burst_cnt, 0);
    stats_en = 1'b0;

    // Clock enable low for 10 clocks mid-line: the model holds, so outputs must be frozen.
    repeat (10) cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0);

    // Synchronous reset asserted while the enable is low; reset must still win.
    cycle(1'b0, 1'b1);
    check("rst_hctr", int'(hctr), 0);
    check("rst_vctr", int'(vctr), 0);
    for (int n = 0; n < 4000; n++) cycle(1'b1, 1'b0);

    check("mono_burst_total", mono_burst_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
